mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port (IF) and its data-access port (MEM stage).
- Serializes requests with fixed priority: data wins over fetch, because the data access belongs to the older instruction.
- Returns read data to the winning requester, and produces stall signals that the segment controller uses to freeze the pipeline.
- Sits between the CPU core and the memory wrapper, replacing separate imem/dmem ports.

Parameters:
- MAX_WAIT, 15, cycles in BUSY without mem_ack before the watchdog aborts the access (range 1..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on a watchdog abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- global_en  in  1  pipeline enable; new grants only when high
- if_req  in  1  fetch request; held stable until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction; registered
- if_ready  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ready
- d_req  in  1  data request; held stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, already lane-aligned
- d_rdata  out  32  load data; registered
- d_ready  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req & ~d_ready
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one cycle; may arrive in the first mem_req cycle
- arb_err  out  1  sticky watchdog-abort flag

Behaviour:
- Reset values: state IDLE; all outputs 0, including rdata registers and arb_err.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - If global_en & d_req, go to BUSY_D; else if global_en & if_req, go to BUSY_I.
  - Latch the selected address, we and wdata into registers; mem_* are driven from these registers.
  - No grant when global_en=0.
- BUSY_x:
  - mem_req=1 with stable address and data.
  - On mem_ack: latch mem_rdata into x_rdata (stores leave d_rdata unchanged) and go to RESP_x.
  - Wait counter increments each BUSY cycle. When the count reaches MAX_WAIT with no ack: drop mem_req, load ERR_DATA into x_rdata, set arb_err, go to RESP_x.
- RESP_x:
  - x_ready=1 and mem_req=0.
  - Stay while global_en=0, so the pulse is never lost while the pipeline is frozen; go to IDLE when global_en=1.
- Latency: req seen at cycle t, mem_req high at t+1, ready at t+2 for a same-cycle ack. One IDLE bubble between any two accesses.
- Simultaneous if_req and d_req: data is granted first; fetch is granted on the following IDLE cycle. Fetch starvation is acceptable because d_req drops after each completion.
- Request deasserted while in BUSY: the access still completes; the ready pulse is ignored by the requester.
- mem_ack in IDLE or RESP: ignored.
- rst mid-access: returns to IDLE next edge and mem_req falls. The memory wrapper must tolerate an abandoned request.
- arb_err clears only on rst.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined: adds outputs perf_if_wait[31:0] and perf_d_wait[31:0], counting the cycles in which if_stall (respectively d_stall) is high. Counters saturate at 32'hFFFFFFFF and clear on rst.
- When undefined: neither the ports nor the logic exist.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (3-bit encoding);
  - the ERR_DATA default;
  - the grant-source encoding (SRC_I = 0, SRC_D = 1).
- One sub-module, mem_arb_watchdog: counter with clear, enable and MAX_WAIT terminal-count output, instantiated once.

Test Plan:
- Lone fetch: if_req, if_addr=0x00400000, memory acks 3 cycles after mem_req with 0x00100073 -> if_ready pulses once, if_rdata=0x00100073, mem_we=0 throughout.
- Contention: if_req and d_req (load 0x10000004) both rise in one cycle -> mem_addr=0x10000004 first and d_ready precedes if_ready; fetch mem_req rises exactly 1 cycle after RESP_D.
- Store with same-cycle ack: d_we=1, d_addr=0x10000000, d_wdata=0x12345678 -> mem_we=1 with that data for 1 cycle; d_ready at t+2; d_rdata unchanged.
- Watchdog: mem_ack never asserted -> mem_req falls after 15 BUSY cycles; if_rdata=0xDEADBEEF, if_ready pulses, arb_err=1 until rst.
- Freeze: global_en=0 when the ack arrives -> ready is held high until global_en=1, then drops after 1 cycle; no new grant while global_en=0.
- Reset mid-BUSY: rst asserted during BUSY_D -> next cycle mem_req=0, state IDLE, d_ready never pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    // Grant source: which requester owns the current access
    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    // Read data returned when the watchdog aborts an access
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter for the arbiter watchdog.
// tc is high in the MAX_WAIT-th consecutive enabled cycle after a clear.
module mem_arb_watchdog #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VALUE = 8'(MAX_WAIT - 1);

    logic [7:0] count;

    assign tc = en && (count == TC_VALUE);

    // Count enabled cycles; hold at terminal count, clear on clr or rst
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port, variable-latency memory
// between the instruction-fetch port and the data port (data wins).
// Optional macro MEM_ARB_PERF_EN adds saturating stall-cycle counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        global_en,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        arb_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_d_wait
`endif
);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        busy;
    logic        wd_tc;
    src_t        grant_src;
    src_t        busy_src;

    assign busy      = (state == BUSY_I) || (state == BUSY_D);
    assign grant_src = d_req ? SRC_D : SRC_I;
    assign busy_src  = (state == BUSY_D) ? SRC_D : SRC_I;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q & mem_req;

    assign if_stall  = if_req & ~if_ready;
    assign d_stall   = d_req & ~d_ready;

    mem_arb_watchdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_watchdog (
        .clk(clk),
        .rst(rst),
        .clr(~busy),
        .en (busy),
        .tc (wd_tc)
    );

    // Arbitration FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            arb_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (global_en && (d_req || if_req)) begin
                        mem_req <= 1'b1;
                        if (grant_src == SRC_D) begin
                            state   <= BUSY_D;
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end else begin
                            state   <= BUSY_I;
                            addr_q  <= if_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack in the terminal-count cycle still completes normally
                    if (mem_ack || wd_tc) begin
                        mem_req <= 1'b0;
                        if (busy_src == SRC_D) begin
                            state   <= RESP_D;
                            d_ready <= 1'b1;
                        end else begin
                            state    <= RESP_I;
                            if_ready <= 1'b1;
                        end
                        if (mem_ack) begin
                            if (busy_src == SRC_I) begin
                                if_rdata <= mem_rdata;
                            end else if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            arb_err <= 1'b1;
                            if (busy_src == SRC_I) begin
                                if_rdata <= ERR_DATA;
                            end else begin
                                d_rdata <= ERR_DATA;
                            end
                        end
                    end
                end
                RESP_I, RESP_D: begin
                    if (global_en) begin
                        state    <= IDLE;
                        if_ready <= 1'b0;
                        d_ready  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Saturating counts of cycles each requester spends stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_stall && (perf_if_wait != '1)) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (d_stall && (perf_d_wait != '1)) begin
                perf_d_wait <= perf_d_wait + 32'd1;
            end
        end
    end
`endif

endmodule
